// File: rtl/perm_pkg.sv
// Shared types and constants for the permission controller.
// Table default and index helper are used by permission_ctrl.
package perm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_RESP
   } state_t;

   localparam logic [63:0] DEF_PERM_TABLE = 64'h0042_FE00_5E00_5A00;

   // Permit-table bit position for a {role,mode} pair.
   function automatic int unsigned perm_index(input int unsigned role,
                                              input int unsigned mode,
                                              input int unsigned mode_w);
      return (role << mode_w) | mode;
   endfunction

endpackage

// File: rtl/permission_ctrl_if.sv
// Request/response bundle between requesting channels and permission_ctrl.
// Channel i role/mode live at [i*W +: W] of the packed role/mode vectors.
interface permission_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int ROLE_W = 3,
   parameter int MODE_W = 3
);
   localparam int CW = $clog2(NUM_CH);

   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH*ROLE_W-1:0] req_role;
   logic [NUM_CH*MODE_W-1:0] req_mode;
   logic [NUM_CH-1:0]        req_ready;
   logic                     grant_valid;
   logic [CW-1:0]            grant_ch;
   logic                     grant_ok;
   logic                     resp_ready;
   logic [NUM_CH-1:0]        locked;

   modport master (
      output req_valid, req_role, req_mode, resp_ready,
      input  req_ready, grant_valid, grant_ch, grant_ok, locked
   );

   modport slave (
      input  req_valid, req_role, req_mode, resp_ready,
      output req_ready, grant_valid, grant_ch, grant_ok, locked
   );

endinterface

// File: rtl/perm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request mask; the pointer moves
// to the channel after the granted one only when the grant is accepted.
module perm_rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CW     = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              accept,
   output logic [NUM_CH-1:0] gnt,
   output logic [CW-1:0]     gnt_idx
);

   logic [CW-1:0] ptr;
   logic          found;
   int unsigned   pos;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         pos = (32'(ptr) + i) % NUM_CH;
         if (!found && req[pos]) begin
            gnt[pos] = 1'b1;
            gnt_idx  = CW'(pos);
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
      end
   end

endmodule

// File: rtl/permission_ctrl.sv
// Permission controller: round-robin request intake, table-based permit check.
// Optional per-channel denial lockout enabled by defining PERM_LOCKOUT_EN.
module permission_ctrl import perm_pkg::*; #(
   parameter int NUM_CH      = 4,
   parameter int ROLE_W      = 3,
   parameter int MODE_W      = 3,
   parameter logic [2**(ROLE_W+MODE_W)-1:0] PERM_TABLE = DEF_PERM_TABLE,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 16
) (
   input logic               clk,
   input logic               rst_n,
   permission_ctrl_if.slave  bus
);

   localparam int CW = $clog2(NUM_CH);
   localparam int TW = ROLE_W + MODE_W;

   if (NUM_CH < 2 || NUM_CH > 16 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_param_chk
      $error("permission_ctrl: parameter out of range");
   end

   state_t              state, state_nxt;
   logic [NUM_CH-1:0]   eligible, arb_gnt, req_ready, locked;
   logic [CW-1:0]       arb_idx;
   logic                accept, eval_en, grant_valid;
   logic [ROLE_W-1:0]   cap_role;
   logic [MODE_W-1:0]   cap_mode;
   logic [CW-1:0]       cap_ch;
   logic                perm_q;
   logic [TW-1:0]       tbl_idx;

   assign eligible = bus.req_valid & ~locked;

   perm_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (eligible),
      .accept  (accept),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // req_ready is combinational from the arbiter, so it is also gated by
   // rst_n to read zero for the whole reset window.
   always_comb begin
      state_nxt   = state;
      req_ready   = '0;
      accept      = 1'b0;
      eval_en     = 1'b0;
      grant_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rst_n) begin
               req_ready = arb_gnt;
               if (|arb_gnt) begin
                  accept    = 1'b1;
                  state_nxt = ST_EVAL;
               end
            end
         end
         ST_EVAL: begin
            eval_en   = 1'b1;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            grant_valid = 1'b1;
            if (bus.resp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign tbl_idx = TW'(perm_index(32'(cap_role), 32'(cap_mode), MODE_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_ch   <= '0;
         cap_role <= '0;
         cap_mode <= '0;
         perm_q   <= 1'b0;
      end else begin
         if (accept) begin
            cap_ch   <= arb_idx;
            cap_role <= bus.req_role[arb_idx*ROLE_W +: ROLE_W];
            cap_mode <= bus.req_mode[arb_idx*MODE_W +: MODE_W];
         end
         if (eval_en) perm_q <= PERM_TABLE[tbl_idx] && (cap_mode != '0);
      end
   end

`ifdef PERM_LOCKOUT_EN
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   logic [FW-1:0] fail_cnt [NUM_CH];
   logic [LW-1:0] lock_cnt [NUM_CH];
   logic          done;

   assign done = (state == ST_RESP) && bus.resp_ready;

   // Reaching MAX_FAIL loads the lock timer on the completion edge itself,
   // so locked rises together with the return to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            fail_cnt[i] <= '0;
            lock_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (lock_cnt[i] != '0) lock_cnt[i] <= lock_cnt[i] - LW'(1);
            if (done && cap_ch == CW'(i)) begin
               if (perm_q) begin
                  fail_cnt[i] <= '0;
               end else if (32'(fail_cnt[i]) + 1 >= MAX_FAIL) begin
                  fail_cnt[i] <= '0;
                  lock_cnt[i] <= LW'(LOCK_CYCLES);
               end else begin
                  fail_cnt[i] <= fail_cnt[i] + FW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      locked = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) locked[i] = (lock_cnt[i] != '0);
   end
`else
   assign locked = '0;
`endif

   assign bus.req_ready   = req_ready;
   assign bus.grant_valid = grant_valid;
   assign bus.grant_ch    = cap_ch;
   assign bus.grant_ok    = perm_q;
   assign bus.locked      = locked;

endmodule

// File: tb/tb_permission_ctrl.sv
// Directed self-checking bench for permission_ctrl (default table, 4 channels).
// Lockout scenarios follow PERM_LOCKOUT_EN when it is defined.
module tb_permission_ctrl;

   localparam int NUM_CH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   permission_ctrl_if #(.NUM_CH(NUM_CH), .ROLE_W(3), .MODE_W(3)) bus ();

   permission_ctrl #(
      .NUM_CH(NUM_CH), .ROLE_W(3), .MODE_W(3), .MAX_FAIL(3), .LOCK_CYCLES(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [2:0] role, input logic [2:0] mode);
      bus.req_role[ch*3 +: 3] = role;
      bus.req_mode[ch*3 +: 3] = mode;
   endtask

   // Full single-channel transaction with resp_ready=1; starts and ends just
   // after a rising edge with the controller idle.
   task automatic do_req(input int ch, input logic [2:0] role, input logic [2:0] mode,
                         input logic exp_ok);
      logic [3:0] exp_rdy;
      exp_rdy = 4'(1 << ch);
      bus.req_valid = '0;
      bus.req_valid[ch] = 1'b1;
      set_ch(ch, role, mode);
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
         failures++;
         $display("FAIL req_ready ch%0d: got %b expected %b", ch, bus.req_ready, exp_rdy);
      end
      step();
      bus.req_valid = '0;
      bus.req_role  = '1;
      bus.req_mode  = '0;
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL eval_quiet ch%0d: got rdy=%b gv=%b expected rdy=0000 gv=0",
                  ch, bus.req_ready, bus.grant_valid);
      end
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'(ch) || bus.grant_ok !== exp_ok) begin
         failures++;
         $display("FAIL resp r%0d m%0d ch%0d: got gv=%b ch=%0d ok=%b expected gv=1 ch=%0d ok=%b",
                  role, mode, ch, bus.grant_valid, bus.grant_ch, bus.grant_ok, ch, exp_ok);
      end
      step();
      checks++;
      if (bus.grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL resp_done ch%0d: got gv=%b expected 0", ch, bus.grant_valid);
      end
   endtask

   task automatic test_reset();
      bus.req_valid  = '1;
      bus.req_role   = '0;
      bus.req_mode   = '0;
      bus.resp_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.grant_ch !== 2'd0 ||
          bus.grant_ok !== 1'b0 || bus.locked !== 4'b0000) begin
         failures++;
         $display("FAIL reset_state: got rdy=%b gv=%b ch=%0d ok=%b lk=%b expected all zero",
                  bus.req_ready, bus.grant_valid, bus.grant_ch, bus.grant_ok, bus.locked);
      end
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = '0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      do_req(0, 3'b101, 3'b011, 1'b1);
   endtask

   task automatic test_perm_table();
      logic [2:0] r  [10];
      logic [2:0] m  [10];
      logic       ok [10];
      r  = '{3'd6, 3'd6, 3'd1, 3'd1, 3'd3, 3'd3, 3'd7, 3'd5, 3'd6, 3'd2};
      m  = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd7, 3'd1, 3'd5, 3'd0, 3'd6, 3'd3};
      ok = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 10; k++) do_req(2, r[k], m[k], ok[k]);
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_rdy [4];
      logic [1:0] exp_ch  [4];
      exp_rdy = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      exp_ch  = '{2'd0, 2'd2, 2'd0, 2'd2};
      bus.req_valid = 4'b0101;
      set_ch(0, 3'b101, 3'b011);
      set_ch(2, 3'b110, 3'b001);
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (bus.req_ready !== exp_rdy[k]) begin
            failures++;
            $display("FAIL rr_order[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy[k]);
         end
         step();
         if (k == 3) bus.req_valid = '0;
         checks++;
         if (bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rr_busy[%0d]: got %b expected 0000", k, bus.req_ready);
         end
         step();
         checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant_ch !== exp_ch[k] || bus.grant_ok !== 1'b1) begin
            failures++;
            $display("FAIL rr_resp[%0d]: got gv=%b ch=%0d ok=%b expected gv=1 ch=%0d ok=1",
                     k, bus.grant_valid, bus.grant_ch, bus.grant_ok, exp_ch[k]);
         end
         @(posedge clk);
      end
      #1;
   endtask

   task automatic test_stall();
      bus.resp_ready = 1'b0;
      bus.req_valid  = 4'b1000;
      set_ch(3, 3'b110, 3'b110);
      #1;
      checks++;
      if (bus.req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL stall_req: got %b expected 1000", bus.req_ready);
      end
      step();
      bus.req_valid = 4'b0010;
      set_ch(1, 3'b001, 3'b011);
      set_ch(3, 3'b000, 3'b000);
      step();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'd3 || bus.grant_ok !== 1'b1 ||
             bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got gv=%b ch=%0d ok=%b rdy=%b expected gv=1 ch=3 ok=1 rdy=0000",
                     k, bus.grant_valid, bus.grant_ch, bus.grant_ok, bus.req_ready);
         end
         if (k < 5) step();
      end
      bus.resp_ready = 1'b1;
      step();
      #1;
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL stall_release: got gv=%b rdy=%b expected gv=0 rdy=0010",
                  bus.grant_valid, bus.req_ready);
      end
      bus.req_valid = '0;
      step();
   endtask

   task automatic test_lockout();
      // Alternating outcomes on ch2 never reach three consecutive denials.
      do_req(2, 3'b110, 3'b000, 1'b0);
      do_req(2, 3'b010, 3'b011, 1'b0);
      do_req(2, 3'b110, 3'b001, 1'b1);
      do_req(2, 3'b110, 3'b000, 1'b0);
      do_req(2, 3'b010, 3'b011, 1'b0);
      checks++;
      if (bus.locked !== 4'b0000) begin
         failures++;
         $display("FAIL no_lock_ch2: got %b expected 0000", bus.locked);
      end
      do_req(1, 3'b000, 3'b001, 1'b0);
      do_req(1, 3'b000, 3'b001, 1'b0);
      checks++;
      if (bus.locked !== 4'b0000) begin
         failures++;
         $display("FAIL lock_early: got %b expected 0000", bus.locked);
      end
      do_req(1, 3'b000, 3'b001, 1'b0);
`ifdef PERM_LOCKOUT_EN
      bus.req_valid = 4'b0010;
      set_ch(1, 3'b001, 3'b011);
      #1;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (bus.locked !== 4'b0010 || bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL lock_window[%0d]: got lk=%b rdy=%b expected lk=0010 rdy=0000",
                     k, bus.locked, bus.req_ready);
         end
         step();
      end
      checks++;
      if (bus.locked !== 4'b0000 || bus.req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL lock_expire: got lk=%b rdy=%b expected lk=0000 rdy=0010",
                  bus.locked, bus.req_ready);
      end
      step();
      bus.req_valid = '0;
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'd1 || bus.grant_ok !== 1'b1) begin
         failures++;
         $display("FAIL lock_after: got gv=%b ch=%0d ok=%b expected gv=1 ch=1 ok=1",
                  bus.grant_valid, bus.grant_ch, bus.grant_ok);
      end
      step();
`else
      checks++;
      if (bus.locked !== 4'b0000) begin
         failures++;
         $display("FAIL lock_disabled: got %b expected 0000", bus.locked);
      end
      do_req(1, 3'b001, 3'b011, 1'b1);
`endif
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_lk;
`ifdef PERM_LOCKOUT_EN
      exp_lk = 4'b0010;
`else
      exp_lk = 4'b0000;
`endif
      do_req(1, 3'b000, 3'b001, 1'b0);
      do_req(1, 3'b000, 3'b001, 1'b0);
      do_req(1, 3'b000, 3'b001, 1'b0);
      checks++;
      if (bus.locked !== exp_lk) begin
         failures++;
         $display("FAIL pre_reset_lock: got %b expected %b", bus.locked, exp_lk);
      end
      bus.resp_ready = 1'b0;
      bus.req_valid  = 4'b0100;
      set_ch(2, 3'b110, 3'b001);
      step();
      bus.req_valid = '0;
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'd2 || bus.grant_ok !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_resp: got gv=%b ch=%0d ok=%b expected gv=1 ch=2 ok=1",
                  bus.grant_valid, bus.grant_ch, bus.grant_ok);
      end
      #3;
      bus.req_valid = 4'b1001;
      set_ch(0, 3'b101, 3'b011);
      set_ch(3, 3'b110, 3'b110);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_ch !== 2'd0 || bus.grant_ok !== 1'b0 ||
          bus.locked !== 4'b0000 || bus.req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset: got gv=%b ch=%0d ok=%b lk=%b rdy=%b expected all zero",
                  bus.grant_valid, bus.grant_ch, bus.grant_ok, bus.locked, bus.req_ready);
      end
      step();
      rst_n = 1'b1;
      bus.resp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL post_reset_ptr: got %b expected 0001", bus.req_ready);
      end
      step();
      bus.req_valid = '0;
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'd0 || bus.grant_ok !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_resp: got gv=%b ch=%0d ok=%b expected gv=1 ch=0 ok=1",
                  bus.grant_valid, bus.grant_ch, bus.grant_ok);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_perm_table();
      test_round_robin();
      test_stall();
      test_lockout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/permission_ctrl.md
PERMISSION_CTRL -- requirements
Module: permission_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels, 2..16.
REQ-002 SHALL have parameter ROLE_W, default 3: role code width per channel.
REQ-003 SHALL have parameter MODE_W, default 3: mode code width per channel.
REQ-004 SHALL have parameter PERM_TABLE, width 2^(ROLE_W+MODE_W), default 64'h0042_FE00_5E00_5A00: permit bit indexed by {role,mode}.
REQ-005 SHALL have parameter MAX_FAIL, default 3: consecutive denials before lockout.
REQ-006 SHALL have parameter LOCK_CYCLES, default 16: lockout duration in clocks.
REQ-007 SHALL have port clk, input, 1: single clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port req_valid, input, NUM_CH: per-channel request.
REQ-010 SHALL have port req_role, input, NUM_CH*ROLE_W: channel i role at [i*ROLE_W +: ROLE_W].
REQ-011 SHALL have port req_mode, input, NUM_CH*MODE_W: channel i mode, same packing.
REQ-012 SHALL have port req_ready, output, NUM_CH: one-hot acceptance strobe.
REQ-013 SHALL have port grant_valid, output, 1: response available.
REQ-014 SHALL have port grant_ch, output, $clog2(NUM_CH): channel being answered.
REQ-015 SHALL have port grant_ok, output, 1: 1 permit, 0 deny.
REQ-016 SHALL have port resp_ready, input, 1: consumer accepts response.
REQ-017 SHALL have port locked, output, NUM_CH: channel in lockout.

Function
REQ-018 SHALL implement FSM IDLE, EVAL, RESP.
REQ-019 In IDLE, req_ready SHALL be one-hot on the round-robin winner among channels with req_valid=1 and locked=0; all-zero when none is eligible.
REQ-020 A request SHALL be accepted on the edge where state=IDLE and req_ready[i]=1; role and mode are captured and the FSM goes to EVAL.
REQ-021 Round-robin priority SHALL start at (last accepted channel + 1) mod NUM_CH; after reset it starts at channel 0.
REQ-022 EVAL SHALL last one cycle and register permit = PERM_TABLE[{role,mode}] AND (mode != 0).
REQ-023 RESP SHALL begin two clocks after acceptance; grant_valid=1; grant_ch and grant_ok remain stable until the edge where resp_ready=1, then the FSM goes to IDLE.
REQ-024 req_ready SHALL be 0 outside IDLE; at most one request is in flight.
REQ-025 Inputs SHALL be ignored after capture; dropping req_valid during EVAL or RESP does not alter the response.
REQ-026 On response completion: grant_ok=1 clears that channel's fail counter; grant_ok=0 increments it, saturating at MAX_FAIL.
REQ-027 When the fail counter reaches MAX_FAIL, locked[i] SHALL rise on that same edge and remain high for exactly LOCK_CYCLES clocks; the counter clears.
REQ-028 A channel whose lock expires SHALL be eligible in the first cycle with locked[i]=0.
REQ-029 Lock countdowns SHALL run independently of FSM state and of other channels.

Reset
REQ-030 Reset assertion SHALL immediately force state IDLE, req_ready=0, grant_valid=0, grant_ch=0, grant_ok=0, locked=0, all fail counters=0, RR pointer=0, even mid-EVAL or mid-RESP; an in-flight response is discarded.

Configuration
REQ-031 With PERM_LOCKOUT_EN defined, SHALL implement REQ-026..REQ-029.
REQ-032 Without PERM_LOCKOUT_EN, no fail or lock counters SHALL exist, locked SHALL be constant 0, and MAX_FAIL and LOCK_CYCLES SHALL be unused.

Structure
REQ-033 Package perm_pkg SHALL hold the FSM state enum, the default PERM_TABLE constant and the table-index function.
REQ-034 Round-robin selection SHALL be the sub-module perm_rr_arbiter (request mask in, one-hot grant out, pointer update on accept).

Verification
REQ-035 Ch0 role=3'b101 mode=3'b011, resp_ready=1 -> req_ready=4'b0001, grant_valid 2 clocks later, grant_ch=0, grant_ok=1.
REQ-036 Ch2 role=3'b110 mode=3'b000 -> grant_ok=0; role=3'b110 mode=3'b001 -> grant_ok=1, fail counter cleared.
REQ-037 Ch1 role=3'b000 mode=3'b001 denied 3 times (lockout on) -> locked[1]=1 for 16 clocks; req_ready[1]=0 throughout; accepted on the first clock after expiry.
REQ-038 Ch0 and ch2 held valid, resp_ready=1 -> accepted order 0,2,0,2.
REQ-039 resp_ready=0 for 5 clocks during RESP -> grant_valid, grant_ch, grant_ok stable; no new req_ready until completion.
REQ-040 rst_n low during RESP -> grant_valid=0 and locked=0 immediately; the next request is served starting from channel 0.
